// File: rtl/simon_decrypt.sv
// Iterative Simon32/64 decryption core: one inverse round per clock, round keys ROUNDS-1 down to 0.
// The round-key bus is captured at accept so it may change freely while a block is in flight.
module simon_decrypt #(
    parameter int unsigned ROUNDS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  ciphertext,
    input  logic [511:0] key_total,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  plaintext,
    output logic         busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    localparam logic [4:0] RcInit = 5'(ROUNDS - 1);

    logic [1:0]   state_q;
    logic [15:0]  x_q, y_q;
    logic [511:0] key_q;
    logic [4:0]   rc_q;
    logic [31:0]  pt_q;

    logic [15:0] round_key;
    logic [15:0] f_y;
    logic [15:0] x_d, y_d;

    always_comb begin
        round_key = key_q[{rc_q, 4'b0000} +: 16];
        f_y       = ({y_q[14:0], y_q[15]} & {y_q[7:0], y_q[15:8]}) ^ {y_q[13:0], y_q[15:14]};
        x_d       = y_q;
        y_d       = x_q ^ f_y ^ round_key;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            key_q   <= '0;
            rc_q    <= '0;
            pt_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        x_q     <= ciphertext[31:16];
                        y_q     <= ciphertext[15:0];
                        key_q   <= key_total;
                        rc_q    <= RcInit;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    // Last inverse round goes straight into the output register.
                    if (rc_q == 5'd0) begin
                        pt_q    <= {x_d, y_d};
                        state_q <= StHold;
                    end else begin
                        rc_q <= rc_q - 5'd1;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q == StRun);
        out_valid = (state_q == StHold);
        plaintext = pt_q;
    end

endmodule

// File: tb/tb_simon_decrypt.sv
// Self-checking bench for simon_decrypt: directed vectors plus a randomized round-trip
// against a forward-cipher reference model.
module tb_simon_decrypt;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  ciphertext;
    logic [511:0] key_total;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  plaintext;
    logic         busy;

    int total;
    int bad;

    simon_decrypt #(.ROUNDS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key_total  (key_total),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: Simon32/64 key schedule and forward encryption.
    function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [15:0] rotr(input logic [15:0] v, input int n);
        return (v >> n) | (v << (16 - n));
    endfunction

    function automatic logic [15:0] ff(input logic [15:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    function automatic logic [511:0] expand(input logic [63:0] k4);
        logic [15:0]  kw [32];
        logic [61:0]  z0;
        logic [15:0]  tmp;
        logic [511:0] bus;
        z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int i = 0; i < 4; i++) kw[i] = k4[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            tmp = rotr(kw[i-1], 3) ^ kw[i-3];
            tmp = tmp ^ rotr(tmp, 1);
            kw[i] = ~kw[i-4] ^ tmp ^ {15'd0, z0[61-(i-4)]} ^ 16'd3;
        end
        for (int i = 0; i < 32; i++) bus[16*i +: 16] = kw[i];
        return bus;
    endfunction

    function automatic logic [31:0] encrypt(input logic [31:0] pt, input logic [511:0] keys);
        logic [15:0] x, y, t;
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ ff(x) ^ keys[16*i +: 16];
            y = t;
        end
        return {x, y};
    endfunction

    // Call at a negedge with the core idle; returns at the negedge after the accept edge.
    task automatic start_block(input logic [31:0] ct, input logic [511:0] keys);
        check_eq("accept_ready", {31'd0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        ciphertext = ct;
        key_total  = keys;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n, output int busy_cnt);
        n = 0;
        busy_cnt = 0;
        while (!out_valid && n < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        if (!out_valid) check_eq("out_timeout", 32'd0, 32'd1);
    endtask

    logic [511:0] std_keys;
    logic [511:0] key_arr [100];
    logic [31:0]  pt_arr  [100];
    logic [31:0]  ct_arr  [100];
    logic [31:0]  exp_q   [$];
    int n, bc, cnt, sent, got, cyc;
    logic acc, dlv;

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        ciphertext = '0;
        key_total = '0;
        std_keys = expand({16'h1918, 16'h1110, 16'h0908, 16'h0100});

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_plaintext", plaintext, 32'd0);

        // Standard vector, out_ready held high.
        out_ready = 1'b1;
        start_block(32'hc69be9bb, std_keys);
        wait_out(n, bc);
        check_eq("std_latency", n, 32'd32);
        check_eq("std_busy_cycles", bc, 32'd32);
        check_eq("std_plaintext", plaintext, 32'h65656877);
        @(negedge clk);
        check_eq("std_out_valid_drop", {31'd0, out_valid}, 32'd0);
        check_eq("std_in_ready_back", {31'd0, in_ready}, 32'd1);
        check_eq("std_pt_held_idle", plaintext, 32'h65656877);

        // Backpressure for 10 cycles.
        out_ready = 1'b0;
        start_block(32'hc69be9bb, std_keys);
        wait_out(n, bc);
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_plaintext", plaintext, 32'h65656877);
            check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_out_valid_drop", {31'd0, out_valid}, 32'd0);
        check_eq("bp_in_ready_back", {31'd0, in_ready}, 32'd1);

        // in_valid pulse mid-run must be ignored.
        start_block(32'hc69be9bb, std_keys);
        repeat (4) @(negedge clk);
        in_valid = 1'b1;
        ciphertext = 32'h0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(n, bc);
        check_eq("ign_plaintext", plaintext, 32'h65656877);
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid || busy) cnt++;
            @(negedge clk);
        end
        check_eq("ign_no_second", cnt, 32'd0);

        // Key bus changed right after accept.
        start_block(32'hc69be9bb, std_keys);
        key_total = '1;
        wait_out(n, bc);
        check_eq("key_stable_pt", plaintext, 32'h65656877);
        @(negedge clk);

        // Reset in the middle of a run.
        start_block(32'hc69be9bb, std_keys);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mrst_busy", {31'd0, busy}, 32'd0);
        check_eq("mrst_plaintext", plaintext, 32'd0);
        start_block(32'hc69be9bb, std_keys);
        wait_out(n, bc);
        check_eq("mrst_latency", n, 32'd32);
        check_eq("mrst_plaintext_after", plaintext, 32'h65656877);
        @(negedge clk);

        // Randomized round-trip, in_valid held high, random out_ready.
        for (int i = 0; i < 100; i++) begin
            key_arr[i] = expand({$urandom, $urandom});
            pt_arr[i]  = $urandom;
            ct_arr[i]  = encrypt(pt_arr[i], key_arr[i]);
        end
        sent = 0;
        got = 0;
        cyc = 0;
        while (got < 100 && cyc < 20000) begin
            in_valid = (sent < 100);
            if (sent < 100) begin
                ciphertext = ct_arr[sent];
                key_total  = key_arr[sent];
            end
            out_ready = 1'($urandom_range(0, 1));
            acc = in_valid && in_ready;
            dlv = out_valid && out_ready;
            if (dlv) begin
                if (exp_q.size() == 0) check_eq("rt_spurious_out", 32'd1, 32'd0);
                else check_eq("rt_plaintext", plaintext, exp_q.pop_front());
                got++;
            end
            if (acc) begin
                exp_q.push_back(pt_arr[sent]);
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("rt_delivered", got, 32'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simon_decrypt.md
Name: simon_decrypt

Overview:
- Iterative Simon32/64 decryption core and the consumer of the round-key bus produced by the team's key-expansion block.
- Accepts one 32-bit ciphertext block per transaction and latches the 512-bit round-key bus at accept.
- Applies one inverse round per clock, using round keys ROUNDS-1 down to 0, and returns the 32-bit plaintext over a valid/ready handshake.

Parameters:
- ROUNDS, 32, number of inverse rounds; legal range 1..32; uses round keys ROUNDS-1..0.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  ciphertext and key bus are valid.
- in_ready  output  1  core can accept a block.
- ciphertext  input  32  block: x = [31:16], y = [15:0].
- key_total  input  512  round key i occupies bits [16i+15:16i]; key 0 is the first encryption round.
- out_valid  output  1  plaintext is valid.
- out_ready  input  1  downstream accepts the plaintext.
- plaintext  output  32  x = [31:16], y = [15:0].
- busy  output  1  high while in RUN.

Behaviour:
- Reset (rst=1 at a clock edge) has priority over everything, including a mid-run or pending-output transaction. The abandoned block is dropped with no output. After reset:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - busy = 0
  - plaintext = 0
  - round counter = 0
- States: IDLE, RUN, HOLD.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch x <- ciphertext[31:16], y <- ciphertext[15:0], key register <- key_total, rc <- ROUNDS-1. Go to RUN.
- RUN:
  - in_ready = 0, busy = 1.
  - Each cycle, with k = key[rc] and f(v) = (rotl1(v) & rotl8(v)) ^ rotl2(v):
    - x_next = y
    - y_next = x ^ f(y) ^ k
  - When rc = 0, this cycle's result is loaded into plaintext and the FSM goes to HOLD with out_valid = 1. Otherwise rc decrements.
- HOLD:
  - out_valid = 1, in_ready = 0, busy = 0.
  - plaintext is stable until out_valid & out_ready. On that event, out_valid drops next cycle and the FSM returns to IDLE.
- Latency:
  - Accept edge at cycle 0; out_valid first asserted after edge ROUNDS (cycle 32 for default).
  - One block in flight. Minimum accept-to-accept spacing is ROUNDS+2 cycles with out_ready held high.
- Simultaneous events:
  - in_valid during RUN or HOLD is ignored, because in_ready = 0. The input is not latched.
  - out_ready while out_valid = 0 has no effect.
- Key bus: sampled only at accept. Changes to key_total during RUN must not affect the result.
- Arithmetic: all ops are 16-bit XOR/AND/rotate; no carries. Rotates are circular left.
- rc is a 5-bit counter; it never wraps because the FSM leaves RUN at rc = 0.
- The plaintext register holds its last value in IDLE.

Test Plan:
- Standard vector: key words 0..3 = 16'h0100, 16'h0908, 16'h1110, 16'h1918 with keys 4..31 expanded per Simon32/64 (z0); ciphertext 32'hc69be9bb, out_ready=1 -> plaintext 32'h65656877, out_valid rising exactly 32 cycles after accept, busy high for those 32 cycles.
- Backpressure: same vector with out_ready=0 for 10 cycles after out_valid -> plaintext held at 32'h65656877 and in_ready=0 throughout; one cycle after out_ready=1, out_valid=0 and in_ready=1.
- Ignored input: pulse in_valid with ciphertext 32'h00000000 at cycle 5 of a run -> result still 32'h65656877; no second out_valid.
- Key stability: drive key_total to all-ones one cycle after accept -> plaintext still 32'h65656877.
- Reset mid-run: assert rst at cycle 15 -> next edge in_ready=1, out_valid=0, busy=0, plaintext=0; a fresh accept then yields 32'h65656877.
- Round-trip: 100 random keys and plaintexts, encrypted by the reference model, back-to-back with random out_ready -> every plaintext matches, and accepts occur only when in_ready=1.
